// File: rtl/axi_rd_native_responder_pkg.sv
// Shared constants and FSM state type for the AXI read-channel responder.
package axi_rd_native_responder_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } rd_state_t;

  function automatic int beat_log2(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_rd_native_responder_if.sv
// AXI read port plus native command/read-data port of the read responder.
interface axi_rd_native_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int ID_W   = 1
);

  logic              axi_ar_valid;
  logic              axi_ar_ready;
  logic [ADDR_W-1:0] axi_ar_payload_addr;
  logic [1:0]        axi_ar_payload_burst;
  logic [7:0]        axi_ar_payload_len;
  logic [3:0]        axi_ar_payload_size;
  logic [ID_W-1:0]   axi_ar_payload_id;
  logic              axi_ar_payload_lock;
  logic [2:0]        axi_ar_payload_prot;
  logic [3:0]        axi_ar_payload_cache;
  logic [3:0]        axi_ar_payload_qos;
  logic              axi_ar_first;
  logic              axi_ar_last;

  logic              axi_r_valid;
  logic              axi_r_ready;
  logic [DATA_W-1:0] axi_r_payload_data;
  logic [1:0]        axi_r_payload_resp;
  logic [ID_W-1:0]   axi_r_payload_id;
  logic              axi_r_first;
  logic              axi_r_last;

  logic              native_cmd_valid;
  logic              native_cmd_ready;
  logic [ADDR_W-1:0] native_cmd_payload_addr;
  logic              native_cmd_payload_we;
  logic              native_cmd_payload_mw;
  logic              native_cmd_first;
  logic              native_cmd_last;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata_payload_data;

  modport slave (
    input  axi_ar_valid, axi_ar_payload_addr, axi_ar_payload_burst, axi_ar_payload_len,
           axi_ar_payload_size, axi_ar_payload_id, axi_ar_payload_lock, axi_ar_payload_prot,
           axi_ar_payload_cache, axi_ar_payload_qos, axi_ar_first, axi_ar_last,
           axi_r_ready, native_cmd_ready, rdata_valid, rdata_payload_data,
    output axi_ar_ready, axi_r_valid, axi_r_payload_data, axi_r_payload_resp, axi_r_payload_id,
           axi_r_first, axi_r_last, native_cmd_valid, native_cmd_payload_addr,
           native_cmd_payload_we, native_cmd_payload_mw, native_cmd_first, native_cmd_last,
           rdata_ready
  );

  modport master (
    output axi_ar_valid, axi_ar_payload_addr, axi_ar_payload_burst, axi_ar_payload_len,
           axi_ar_payload_size, axi_ar_payload_id, axi_ar_payload_lock, axi_ar_payload_prot,
           axi_ar_payload_cache, axi_ar_payload_qos, axi_ar_first, axi_ar_last,
           axi_r_ready, native_cmd_ready, rdata_valid, rdata_payload_data,
    input  axi_ar_ready, axi_r_valid, axi_r_payload_data, axi_r_payload_resp, axi_r_payload_id,
           axi_r_first, axi_r_last, native_cmd_valid, native_cmd_payload_addr,
           native_cmd_payload_we, native_cmd_payload_mw, native_cmd_first, native_cmd_last,
           rdata_ready
  );

endinterface

// File: rtl/axi_rd_native_responder.sv
// AXI4 read responder: splits each AR burst into single-beat native reads and
// returns the native data, in command order, as R beats through one output register.
//
// state | meaning
// IDLE  | waiting for AR (axi_ar_ready high)
// ISSUE | legal burst: issuing native commands, collecting read data
// DRAIN | all commands issued, returning the remaining R beats
// ERR   | illegal burst: returning len+1 SLVERR beats, no native traffic
module axi_rd_native_responder
  import axi_rd_native_responder_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 256,
  parameter int ID_W            = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                     clk,
  input logic                     rst,
  axi_rd_native_responder_if.slave bus
);

  localparam int BEAT_LOG2 = beat_log2(DATA_W);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING) + 1;

  rd_state_t         state;
  rd_state_t         state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        burst_q;
  logic [7:0]        len_q;
  logic [ID_W-1:0]   id_q;
  logic [8:0]        cmds_left;
  logic [8:0]        beat_cnt;
  logic [OUT_W-1:0]  outstanding;

  logic              r_valid_q;
  logic [DATA_W-1:0] r_data_q;
  logic [1:0]        r_resp_q;

  logic              ar_ready;
  logic              cmd_valid;
  logic              rdata_ready;

  logic              ar_fire;
  logic              ar_legal;
  logic              cmd_fire;
  logic              rdata_fire;
  logic              r_fire;
  logic              r_last;

  assign ar_fire    = bus.axi_ar_valid && ar_ready;
  assign ar_legal   = (bus.axi_ar_payload_burst != AXI_BURST_WRAP) &&
                      (bus.axi_ar_payload_size == 4'(BEAT_LOG2));
  assign cmd_fire   = cmd_valid && bus.native_cmd_ready;
  assign rdata_fire = bus.rdata_valid && rdata_ready;
  assign r_fire     = r_valid_q && bus.axi_r_ready;
  assign r_last     = r_valid_q && (beat_cnt == {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ar_fire) begin
          state_next = ar_legal ? ST_ISSUE : ST_ERR;
        end
      end
      ST_ISSUE: begin
        if (cmd_fire && (cmds_left == 9'd1)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN, ST_ERR: begin
        if (r_fire && r_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Native data is only accepted while a legal burst is active; the output
  // register takes a new beat whenever it is empty or being emptied.
  always_comb begin
    ar_ready    = 1'b0;
    cmd_valid   = 1'b0;
    rdata_ready = 1'b0;
    case (state)
      ST_IDLE:  ar_ready = !rst;
      ST_ISSUE: begin
        cmd_valid   = (outstanding < OUT_W'(MAX_OUTSTANDING)) && (cmds_left != 9'd0);
        rdata_ready = !r_valid_q || bus.axi_r_ready;
      end
      ST_DRAIN: rdata_ready = !r_valid_q || bus.axi_r_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      burst_q   <= '0;
      len_q     <= '0;
      id_q      <= '0;
      cmds_left <= '0;
    end else if (ar_fire) begin
      addr_q    <= bus.axi_ar_payload_addr;
      burst_q   <= bus.axi_ar_payload_burst;
      len_q     <= bus.axi_ar_payload_len;
      id_q      <= bus.axi_ar_payload_id;
      cmds_left <= ar_legal ? ({1'b0, bus.axi_ar_payload_len} + 9'd1) : 9'd0;
    end else if (cmd_fire) begin
      cmds_left <= cmds_left - 9'd1;
      if (burst_q == AXI_BURST_INCR) begin
        addr_q <= addr_q + (ADDR_W'(1) << BEAT_LOG2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({cmd_fire, rdata_fire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (state_next == ST_IDLE) begin
      beat_cnt <= '0;
    end else if (r_fire) begin
      beat_cnt <= beat_cnt + 9'd1;
    end
  end

  // Error bursts reuse the output register: it stays full with a zero SLVERR
  // beat until the last one is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= AXI_RESP_OKAY;
    end else if (ar_fire && !ar_legal) begin
      r_valid_q <= 1'b1;
      r_data_q  <= '0;
      r_resp_q  <= AXI_RESP_SLVERR;
    end else if (rdata_fire) begin
      r_valid_q <= 1'b1;
      r_data_q  <= bus.rdata_payload_data;
      r_resp_q  <= AXI_RESP_OKAY;
    end else if (r_fire) begin
      r_valid_q <= (state == ST_ERR) && !r_last;
    end
  end

  assign bus.axi_ar_ready            = ar_ready;
  assign bus.native_cmd_valid        = cmd_valid;
  assign bus.rdata_ready             = rdata_ready;
  assign bus.native_cmd_payload_addr = addr_q >> BEAT_LOG2;
  assign bus.native_cmd_payload_we   = 1'b0;
  assign bus.native_cmd_payload_mw   = 1'b0;
  assign bus.native_cmd_first        = 1'b1;
  assign bus.native_cmd_last         = 1'b1;

  assign bus.axi_r_valid        = r_valid_q;
  assign bus.axi_r_payload_data = r_data_q;
  assign bus.axi_r_payload_resp = r_resp_q;
  assign bus.axi_r_payload_id   = id_q;
  assign bus.axi_r_first        = r_valid_q && (beat_cnt == 9'd0);
  assign bus.axi_r_last         = r_last;

  logic unused_ar_sideband;
  assign unused_ar_sideband = ^{bus.axi_ar_payload_lock, bus.axi_ar_payload_prot,
                                bus.axi_ar_payload_cache, bus.axi_ar_payload_qos,
                                bus.axi_ar_first, bus.axi_ar_last};

endmodule

// File: tb/tb_axi_rd_native_responder.sv
// Bench for axi_rd_native_responder: AXI master + in-order native memory model
// with a scoreboard of expected native commands and R beats.
module tb_axi_rd_native_responder;

  logic clk;
  logic rst;

  axi_rd_native_responder_if #(.ADDR_W(32), .DATA_W(256), .ID_W(1)) bus ();

  axi_rd_native_responder #(
    .ADDR_W(32), .DATA_W(256), .ID_W(1), .MAX_OUTSTANDING(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [3:0]  size;
    logic        id;
  } ar_t;

  typedef struct packed {
    logic [255:0] data;
    logic [1:0]   resp;
    logic         id;
    logic         first;
    logic         last;
  } beat_t;

  ar_t          ar_q[$];
  logic [31:0]  exp_cmd[$];
  beat_t        exp_r[$];
  logic [255:0] nat_q[$];

  int errors = 0;
  int checks = 0;
  int exp_seq = 0;
  int nat_seq = 0;
  int outst = 0;
  int cmd_fires = 0;
  int r_fires = 0;

  int r_mode = 0;
  bit cmd_rand = 0;
  bit gap_rand = 0;
  bit hold_rdata = 0;
  bit chk_rdy = 0;

  bit          prev_r_stall = 0;
  beat_t       prev_r;
  bit          prev_cmd_stall = 0;
  logic [31:0] prev_cmd_addr;

  function automatic logic [255:0] mk_data(input logic [31:0] waddr, input int seq);
    return {32'(seq), waddr, {6{waddr ^ 32'(seq) ^ 32'h5A5A_C3C3}}};
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_ar(input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len,
                         input logic [3:0] size, input logic id);
    logic [31:0] a;
    beat_t b;
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      b.id    = id;
      b.first = (k == 0);
      b.last  = (k == int'(len));
      if (burst != 2'd2 && size == 4'd5) begin
        exp_cmd.push_back(a >> 5);
        b.data = mk_data(a >> 5, exp_seq);
        b.resp = 2'd0;
        exp_seq++;
        if (burst == 2'd1) a = a + 32'd32;
      end else begin
        b.data = '0;
        b.resp = 2'd2;
      end
      exp_r.push_back(b);
    end
    ar_q.push_back('{addr: addr, burst: burst, len: len, size: size, id: id});
  endtask

  // Bus agent: drives inputs each negedge, then scores the handshakes that
  // will complete at the following posedge.
  initial begin : agent
    beat_t got;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.axi_ar_valid     = 1'b0;
        bus.native_cmd_ready = 1'b0;
        bus.rdata_valid      = 1'b0;
        bus.axi_r_ready      = 1'b0;
        prev_r_stall   = 0;
        prev_cmd_stall = 0;
        continue;
      end
      case (r_mode)
        0:       bus.axi_r_ready = 1'b1;
        1:       bus.axi_r_ready = !bus.axi_r_ready;
        default: bus.axi_r_ready = 1'($urandom_range(0, 1));
      endcase
      bus.native_cmd_ready = cmd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!hold_rdata && nat_q.size() > 0 && (!gap_rand || $urandom_range(0, 2) != 0)) begin
        bus.rdata_valid        = 1'b1;
        bus.rdata_payload_data = nat_q[0];
      end else begin
        bus.rdata_valid        = 1'b0;
        bus.rdata_payload_data = '0;
      end
      if (ar_q.size() > 0) begin
        bus.axi_ar_valid         = 1'b1;
        bus.axi_ar_payload_addr  = ar_q[0].addr;
        bus.axi_ar_payload_burst = ar_q[0].burst;
        bus.axi_ar_payload_len   = ar_q[0].len;
        bus.axi_ar_payload_size  = ar_q[0].size;
        bus.axi_ar_payload_id    = ar_q[0].id;
      end else begin
        bus.axi_ar_valid = 1'b0;
      end
      #1;
      if (bus.axi_ar_valid && bus.axi_ar_ready) void'(ar_q.pop_front());

      if (bus.native_cmd_valid) begin
        checks++;
        if (outst >= 4) begin
          errors++;
          $display("FAIL cmd_outstanding: cmd_valid with %0d outstanding, limit 4", outst);
        end
      end
      if (prev_cmd_stall) begin
        checks++;
        if (bus.native_cmd_valid !== 1'b1 || bus.native_cmd_payload_addr !== prev_cmd_addr) begin
          errors++;
          $display("FAIL cmd_stable: got valid=%b addr=%h, required valid=1 addr=%h",
                   bus.native_cmd_valid, bus.native_cmd_payload_addr, prev_cmd_addr);
        end
      end
      if (chk_rdy && nat_q.size() > 0) begin
        checks++;
        if (bus.rdata_ready !== (!bus.axi_r_valid || bus.axi_r_ready)) begin
          errors++;
          $display("FAIL rdata_ready: got %b, required %b", bus.rdata_ready,
                   !bus.axi_r_valid || bus.axi_r_ready);
        end
      end
      if (bus.native_cmd_valid && bus.native_cmd_ready) begin
        cmd_fires++;
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got addr=%h, required no command", bus.native_cmd_payload_addr);
        end else begin
          if (bus.native_cmd_payload_addr !== exp_cmd[0]) begin
            errors++;
            $display("FAIL cmd_addr: got %h, required %h", bus.native_cmd_payload_addr, exp_cmd[0]);
          end
          void'(exp_cmd.pop_front());
        end
        nat_q.push_back(mk_data(bus.native_cmd_payload_addr, nat_seq));
        nat_seq++;
        outst++;
      end
      if (bus.rdata_valid && bus.rdata_ready) begin
        void'(nat_q.pop_front());
        outst--;
      end

      got = {bus.axi_r_payload_data, bus.axi_r_payload_resp, bus.axi_r_payload_id,
             bus.axi_r_first, bus.axi_r_last};
      if (prev_r_stall) begin
        checks++;
        if (bus.axi_r_valid !== 1'b1 || got !== prev_r) begin
          errors++;
          $display("FAIL r_stable: got valid=%b resp=%0d first=%b last=%b, required held beat resp=%0d first=%b last=%b",
                   bus.axi_r_valid, got.resp, got.first, got.last, prev_r.resp, prev_r.first, prev_r.last);
        end
      end
      if (bus.axi_r_valid && bus.axi_r_ready) begin
        r_fires++;
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got beat resp=%0d, required no beat", got.resp);
        end else begin
          if (got.data !== exp_r[0].data) begin
            errors++;
            $display("FAIL r_data: got %h, required %h", got.data, exp_r[0].data);
          end
          checks++;
          if (got.resp !== exp_r[0].resp || got.id !== exp_r[0].id) begin
            errors++;
            $display("FAIL r_resp_id: got resp=%0d id=%0d, required resp=%0d id=%0d",
                     got.resp, got.id, exp_r[0].resp, exp_r[0].id);
          end
          checks++;
          if (got.first !== exp_r[0].first || got.last !== exp_r[0].last) begin
            errors++;
            $display("FAIL r_first_last: got first=%b last=%b, required first=%b last=%b",
                     got.first, got.last, exp_r[0].first, exp_r[0].last);
          end
          void'(exp_r.pop_front());
        end
      end
      prev_r_stall   = bus.axi_r_valid && !bus.axi_r_ready;
      prev_r         = got;
      prev_cmd_stall = bus.native_cmd_valid && !bus.native_cmd_ready;
      prev_cmd_addr  = bus.native_cmd_payload_addr;
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_r.size() != 0 || exp_cmd.size() != 0 || ar_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_r.size() != 0 || exp_cmd.size() != 0 || ar_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats and %0d cmds still pending after %0d cycles, required 0",
               name, exp_r.size(), exp_cmd.size(), budget);
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({bus.axi_ar_ready, bus.axi_r_valid, bus.native_cmd_valid, bus.rdata_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valids: got ar_ready,r_valid,cmd_valid,rdata_ready=%b, required 0000",
               {bus.axi_ar_ready, bus.axi_r_valid, bus.native_cmd_valid, bus.rdata_ready});
    end
    checks++;
    if (bus.axi_r_payload_data !== '0 || bus.axi_r_payload_resp !== 2'd0 ||
        bus.axi_r_first !== 1'b0 || bus.axi_r_last !== 1'b0 || bus.native_cmd_payload_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_payload: got resp=%0d first=%b last=%b cmd_addr=%h, required zeros",
               bus.axi_r_payload_resp, bus.axi_r_first, bus.axi_r_last, bus.native_cmd_payload_addr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.axi_ar_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ar_ready: got %b, required 1", bus.axi_ar_ready);
    end
  endtask

  task automatic test_incr();
    push_ar(32'h1000, 2'd1, 8'd3, 4'd5, 1'b1);
    wait_drain(200, "incr");
    checks++;
    if (bus.axi_ar_ready !== 1'b1) begin
      errors++;
      $display("FAIL incr_idle: ar_ready got %b, required 1", bus.axi_ar_ready);
    end
  endtask

  task automatic test_fixed();
    push_ar(32'h40, 2'd0, 8'd2, 4'd5, 1'b0);
    wait_drain(200, "fixed");
  endtask

  task automatic test_illegal();
    int n;
    int cmd_seen;
    n = 0;
    cmd_seen = 0;
    push_ar(32'h500, 2'd2, 8'd1, 4'd5, 1'b1);
    push_ar(32'h600, 2'd1, 8'd0, 4'd4, 1'b0);
    while ((exp_r.size() != 0 || ar_q.size() != 0) && n < 200) begin
      tick();
      n++;
      if (bus.native_cmd_valid === 1'b1) cmd_seen++;
    end
    checks++;
    if (exp_r.size() != 0) begin
      errors++;
      $display("FAIL illegal_drain: %0d beats pending, required 0", exp_r.size());
    end
    checks++;
    if (cmd_seen != 0) begin
      errors++;
      $display("FAIL illegal_no_cmd: got %0d cmd_valid cycles, required 0", cmd_seen);
    end
    tick();
  endtask

  task automatic test_outstanding();
    int base;
    base = cmd_fires;
    hold_rdata = 1;
    push_ar(32'h2000, 2'd1, 8'd7, 4'd5, 1'b0);
    repeat (20) tick();
    checks++;
    if (cmd_fires - base != 4) begin
      errors++;
      $display("FAIL outstanding_cmds: got %0d cmds while data withheld, required 4", cmd_fires - base);
    end
    checks++;
    if (bus.native_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL outstanding_valid: got cmd_valid=%b, required 0", bus.native_cmd_valid);
    end
    hold_rdata = 0;
    wait_drain(300, "outstanding");
    checks++;
    if (cmd_fires - base != 8) begin
      errors++;
      $display("FAIL outstanding_total: got %0d cmds, required 8", cmd_fires - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = r_fires;
    r_mode = 1;
    chk_rdy = 1;
    push_ar(32'h3000, 2'd1, 8'd5, 4'd5, 1'b1);
    wait_drain(300, "backpressure");
    checks++;
    if (r_fires - base != 6) begin
      errors++;
      $display("FAIL backpressure_beats: got %0d beats, required 6", r_fires - base);
    end
    r_mode = 0;
    chk_rdy = 0;
  endtask

  task automatic test_back_to_back();
    int rb;
    int cb;
    rb = r_fires;
    cb = cmd_fires;
    r_mode = 2;
    cmd_rand = 1;
    gap_rand = 1;
    chk_rdy = 1;
    push_ar(32'h0, 2'd1, 8'd0, 4'd5, 1'b0);
    push_ar(32'h5020, 2'd0, 8'd1, 4'd5, 1'b1);
    push_ar(32'hFFFF_FFE0, 2'd1, 8'd1, 4'd5, 1'b0);
    push_ar(32'h700, 2'd1, 8'd2, 4'd4, 1'b1);
    push_ar(32'h100, 2'd1, 8'd15, 4'd5, 1'b1);
    wait_drain(3000, "back_to_back");
    checks++;
    if (r_fires - rb != 24 || cmd_fires - cb != 21) begin
      errors++;
      $display("FAIL b2b_counts: got beats=%0d cmds=%0d, required beats=24 cmds=21",
               r_fires - rb, cmd_fires - cb);
    end
    r_mode = 0;
    cmd_rand = 0;
    gap_rand = 0;
    chk_rdy = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    base = r_fires;
    n = 0;
    push_ar(32'h4000, 2'd1, 8'd3, 4'd5, 1'b1);
    while (r_fires - base < 2 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (r_fires - base < 2) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d beats, required 2", r_fires - base);
    end
    rst = 1'b1;
    ar_q.delete();
    exp_cmd.delete();
    exp_r.delete();
    nat_q.delete();
    outst = 0;
    exp_seq = 0;
    nat_seq = 0;
    tick();
    checks++;
    if ({bus.axi_ar_ready, bus.axi_r_valid, bus.native_cmd_valid, bus.rdata_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_valids: got ar_ready,r_valid,cmd_valid,rdata_ready=%b, required 0000",
               {bus.axi_ar_ready, bus.axi_r_valid, bus.native_cmd_valid, bus.rdata_ready});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.axi_ar_ready !== 1'b1 || bus.axi_r_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got ar_ready=%b r_valid=%b, required 1 0",
               bus.axi_ar_ready, bus.axi_r_valid);
    end
    push_ar(32'h8000, 2'd1, 8'd0, 4'd5, 1'b0);
    wait_drain(100, "reset_mid_recover");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst = 1'b1;
    bus.axi_ar_valid         = 1'b0;
    bus.axi_ar_payload_addr  = '0;
    bus.axi_ar_payload_burst = '0;
    bus.axi_ar_payload_len   = '0;
    bus.axi_ar_payload_size  = '0;
    bus.axi_ar_payload_id    = '0;
    bus.axi_ar_payload_lock  = 1'b0;
    bus.axi_ar_payload_prot  = '0;
    bus.axi_ar_payload_cache = '0;
    bus.axi_ar_payload_qos   = '0;
    bus.axi_ar_first         = 1'b0;
    bus.axi_ar_last          = 1'b0;
    bus.axi_r_ready          = 1'b0;
    bus.native_cmd_ready     = 1'b0;
    bus.rdata_valid          = 1'b0;
    bus.rdata_payload_data   = '0;

    test_reset();
    test_incr();
    test_fixed();
    test_illegal();
    test_outstanding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
